// File: rtl/iter_divider.sv
// Multi-cycle signed restoring divider: one quotient bit per clock through a
// 32-bit carry-lookahead adder, with sign fix-up after the magnitude loop.

module cla_32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum,
  output logic        o_cout
);
  logic [31:0] w_g;
  logic [31:0] w_p;
  logic [32:0] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Carries resolved by lookahead inside each 4-bit group, rippling between groups
  always_comb begin
    w_c    = 33'd0;
    w_c[0] = i_cin;
    for (int k = 0; k < 8; k++) begin
      w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_c[4*k]);
      w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
      w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
      w_c[4*k+4] = w_g[4*k+3] | (w_p[4*k+3] & w_g[4*k+2])
                 | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                 | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
    end
  end

  assign o_sum  = w_p ^ w_c[31:0];
  assign o_cout = w_c[32];
endmodule

module negate_32 (
  input  logic [31:0] i_x,
  output logic [31:0] o_y
);
  assign o_y = ~i_x + 32'd1;
endmodule

module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             exception,
  output logic             busy,
  output logic             result_rdy
);
  generate
    if (WIDTH != 32) begin : g_width_check
      $error("iter_divider: only WIDTH=32 is supported");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_cnt;
  logic [31:0] r_q;
  logic [31:0] r_r;
  logic [31:0] r_div;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_exc;

  logic        w_accept;
  logic        w_div0;
  logic        w_ovf;
  logic        w_shift_out;
  logic [31:0] w_r_sh;
  logic [31:0] w_sum;
  logic        w_cout;
  logic        w_t_pos;
  logic [31:0] w_neg_a_in;
  logic [31:0] w_neg_b_in;
  logic [31:0] w_neg_a;
  logic [31:0] w_neg_b;

  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_div0   = (divisor == 32'd0);
  assign w_ovf    = (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);

  // Trial subtract {shift_out, R} - {0, |divisor|}; non-negative when bit 32 clears
  assign w_shift_out = r_r[31];
  assign w_r_sh      = {r_r[30:0], r_q[31]};
  assign w_t_pos     = w_shift_out ^ w_cout;

  cla_32 u_trial (
    .i_a    (w_r_sh),
    .i_b    (~r_div),
    .i_cin  (1'b1),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // The negators take operand magnitudes at start and apply signs in FIX
  assign w_neg_a_in = (r_state == S_FIX) ? r_q : dividend;
  assign w_neg_b_in = (r_state == S_FIX) ? r_r : divisor;

  negate_32 u_neg_a (.i_x(w_neg_a_in), .o_y(w_neg_a));
  negate_32 u_neg_b (.i_x(w_neg_b_in), .o_y(w_neg_b));

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          if (w_div0 || w_ovf) w_next = S_DONE;
          else                 w_next = S_RUN;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_RUN: begin
        if (r_cnt == 5'd31) w_next = S_FIX;
        else                w_next = S_RUN;
      end
      S_FIX:   w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register, iteration datapath and registered result outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 5'd0;
      r_q        <= 32'd0;
      r_r        <= 32'd0;
      r_div      <= 32'd0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_exc      <= 1'b0;
      quotient   <= 32'd0;
      remainder  <= 32'd0;
      exception  <= 1'b0;
      busy       <= 1'b0;
      result_rdy <= 1'b0;
    end else begin
      r_state    <= w_next;
      result_rdy <= 1'b0;
      case (r_state)
        S_RUN: begin
          r_cnt <= r_cnt + 5'd1;
          r_q   <= {r_q[30:0], w_t_pos};
          r_r   <= w_t_pos ? w_sum : w_r_sh;
        end
        S_FIX: begin
          if (r_neg_q) r_q <= w_neg_a;
          if (r_neg_r) r_r <= w_neg_b;
          r_exc <= 1'b0;
        end
        S_DONE: begin
          quotient   <= r_q;
          remainder  <= r_r;
          exception  <= r_exc;
          result_rdy <= 1'b1;
          busy       <= 1'b0;
        end
        default: ;
      endcase
      if (w_accept) begin
        busy    <= 1'b1;
        r_cnt   <= 5'd0;
        r_neg_q <= dividend[31] ^ divisor[31];
        r_neg_r <= dividend[31];
        r_div   <= divisor[31] ? w_neg_b : divisor;
        if (w_div0) begin
          r_q   <= 32'd0;
          r_r   <= dividend;
          r_exc <= 1'b1;
        end else if (w_ovf) begin
          r_q   <= 32'h8000_0000;
          r_r   <= 32'd0;
          r_exc <= 1'b1;
        end else begin
          r_q   <= dividend[31] ? w_neg_a : dividend;
          r_r   <= 32'd0;
          r_exc <= 1'b0;
        end
      end
    end
  end
endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
- Multi-cycle signed integer divider for the ALU's multdiv path.
- Computes quotient and remainder of two's-complement operands by restoring shift-subtract, one quotient bit per clock.
- It is the inverse arithmetic direction of the existing carry-lookahead adders. Each trial subtraction is A + ~B + 1 on cla_32.
- Sits beside the multiplier; the pipeline stalls on busy until result_rdy.

Parameters:
- WIDTH, 32, operand/result width. Only 32 is supported because the trial subtraction is a cla_32 instance. Any other value is a compile-time error.

Ports:
- clock  input  1  system clock, all state updates on the rising edge
- reset  input  1  synchronous, active-high
- start  input  1  one-cycle request; operands sampled on the same edge
- dividend  input  WIDTH  signed dividend
- divisor  input  WIDTH  signed divisor
- quotient  output  WIDTH  signed quotient, truncated toward zero
- remainder  output  WIDTH  signed remainder, sign follows the dividend
- exception  output  1  divide-by-zero or overflow flag for the last result
- busy  output  1  high while a division is in progress
- result_rdy  output  1  one-cycle pulse when quotient, remainder and exception are valid

Behaviour:
- Reset, synchronous, active-high:
  - state goes to IDLE.
  - quotient, remainder, exception, busy and result_rdy all go to 0.
  - Reset wins over start in the same cycle.
  - Reset mid-division aborts the operation with no result_rdy.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - start=1 captures |dividend|, |divisor|, dividend sign and quotient sign (sign XOR).
  - Loads iteration counter = 0 and partial remainder = 0, then goes to RUN.
  - busy=1 from the next cycle.
- Divide-by-zero (divisor==0 at start):
  - Goes directly to DONE.
  - quotient=0, remainder=dividend, exception=1.
- Overflow (dividend=0x80000000, divisor=0xFFFFFFFF):
  - Goes directly to DONE.
  - quotient=0x80000000, remainder=0, exception=1.
- RUN, one iteration per cycle, 32 cycles, counter 0..31:
  - Shift {R, Q} left by 1, bringing the MSB of the dividend register into R.
  - Trial T = {shifted-out bit, R} − {0, |divisor|} over WIDTH+1 bits. The low 32 bits come from cla_32 with ~divisor and Cin=1. Bit 32 is combined from the shifted-out bit and Cout.
  - If T ≥ 0: R ← T[31:0] and quotient bit = 1. Otherwise R is unchanged and the bit = 0.
  - After counter==31, go to FIX.
- FIX, 1 cycle:
  - Negate Q if the quotient sign is set.
  - Negate R if the dividend sign is set.
  - Use the existing negator for both.
  - exception=0. Go to DONE.
- DONE, 1 cycle:
  - Registered outputs are updated, result_rdy=1, busy=0, then go to IDLE.
- Latency, start sampled at edge N:
  - Normal case: result_rdy is high during the cycle after edge N+34 (1 load + 32 RUN + 1 FIX).
  - Exception case: result_rdy is high after edge N+1.
- Holding and acceptance:
  - quotient, remainder and exception hold their values until the next DONE or reset.
  - Back-to-back: start is accepted in the DONE cycle or any IDLE cycle.
  - start while busy (RUN/FIX) is ignored. The in-flight operation completes unaffected.
- Edge cases:
  - |−2^31| is represented as 0x80000000 unsigned magnitude. The trial-subtract width handles it.
  - Operands may change after the start edge without effect.

Test Plan:
- reset, then start with 100 / 7 -> result_rdy pulses once 34 edges later; quotient=14, remainder=2, exception=0; busy high for exactly 34 cycles.
- Signed cases -100/7, 100/−7, −100/−7 -> (−14, −2), (−14, 2), (14, −2); all exception=0.
- 12345 / 0 -> result_rdy after 1 edge; quotient=0, remainder=12345, exception=1. Then 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, exception=1.
- 0x80000000 / 2 -> quotient=0xC0000000, remainder=0. Then 0x7FFFFFFF / 0x7FFFFFFF -> quotient=1, remainder=0. Then 5 / 9 -> quotient=0, remainder=5.
- start asserted again at cycle 10 of a run with different operands -> ignored; first result is unchanged. Then start in the DONE cycle -> accepted; second result arrives 34 edges later.
- reset asserted at cycle 20 of a run -> next cycle shows IDLE and all outputs 0; no result_rdy appears. A random signed regression of 10k ops is checked against the reference model (/ and %), including exceptions.
